// File: rtl/subtractor_seq_n_if.sv
// Start/done handshake bundle for subtractor_seq_n.
// master drives start/A/B; slave returns busy/done/D/Bout/V.
interface subtractor_seq_n_if #(
  parameter int W = 16
);
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         V;

  modport master (
    output start, A, B,
    input  busy, done, D, Bout, V
  );

  modport slave (
    input  start, A, B,
    output busy, done, D, Bout, V
  );
endinterface

// File: rtl/subtractor_seq_n.sv
// Multi-cycle W-bit subtractor, one N-bit chunk per clock, borrow chained
// through a register. Ports: clk, reset (async, active-high), bus (slave:
// start/A/B in; busy/done/D/Bout/V out). Macro SUB_SIGNED_OVF_EN adds V.
module subtractor_seq_n #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                reset,
  subtractor_seq_n_if.slave   bus
);
  localparam int K  = W / N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_d;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic            r_bout;
  logic [N-1:0]    w_a_ch;
  logic [N-1:0]    w_b_ch;
  logic [N:0]      w_sum;
  logic            w_accept;
  logic            w_last;

  // start is only honoured while not busy (IDLE or DONE)
  assign w_accept = bus.start && (r_state != S_RUN);
  assign w_last   = (r_idx == IW'(K - 1));

  assign w_a_ch = r_a[int'(r_idx) * N +: N];
  assign w_b_ch = r_b[int'(r_idx) * N +: N];

  // A - B as A + ~B + 1; carry out of a chunk is the inverted borrow
  assign w_sum = {1'b0, w_a_ch} + {1'b0, ~w_b_ch} + (N + 1)'(r_carry);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (bus.start) w_next = S_RUN;
      S_RUN:  if (w_last)    w_next = S_DONE;
      S_DONE: w_next = bus.start ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (r_state == S_RUN);
    bus.done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_d     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b1;
      r_bout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.A;
      r_b     <= bus.B;
      r_idx   <= '0;
      r_carry <= 1'b1;
    end else if (r_state == S_RUN) begin
      r_d[int'(r_idx) * N +: N] <= w_sum[N-1:0];
      r_carry <= w_sum[N];
      r_idx   <= w_last ? '0 : r_idx + IW'(1);
      if (w_last) r_bout <= ~w_sum[N];
    end
  end

  assign bus.D    = r_d;
  assign bus.Bout = r_bout;

`ifdef SUB_SIGNED_OVF_EN
  logic r_v;

  // top chunk's MSB is the result sign, available on the last RUN edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v <= 1'b0;
    end else if (!w_accept && r_state == S_RUN && w_last) begin
      r_v <= (r_a[W-1] ^ r_b[W-1]) & (w_sum[N-1] ^ r_a[W-1]);
    end
  end

  assign bus.V = r_v;
`else
  assign bus.V = 1'b0;
`endif
endmodule

// File: tb/tb_subtractor_seq_n.sv
// Directed bench for subtractor_seq_n: W=16/N=8 main DUT,
// W=8/N=4 sweep DUT and a K=1 (W=N=8) DUT.
module tb_subtractor_seq_n;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;
  logic expv;

  always #5 clk = ~clk;

  subtractor_seq_n_if #(.W(16)) b16 ();
  subtractor_seq_n_if #(.W(8))  b8 ();
  subtractor_seq_n_if #(.W(8))  b1 ();

  subtractor_seq_n #(.N(8), .W(16)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (b16.slave)
  );

  subtractor_seq_n #(.N(4), .W(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (b8.slave)
  );

  subtractor_seq_n #(.N(8), .W(8)) dutk1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1.slave)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // issue one op on b16 from a negedge; return at the negedge done is seen
  task automatic run16(input logic [15:0] a,
                       input logic [15:0] b,
                       output int lat,
                       output logic bsy1);
    b16.A = a;
    b16.B = b;
    b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    lat = 1;
    bsy1 = b16.busy;
    while (!b16.done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int   lat;
    int   ndone;
    int   s;
    logic bsy;
    logic [7:0] bv;
    logic [7:0] blist [8] = '{8'h00, 8'h01, 8'h0F, 8'h10,
                              8'h7F, 8'h80, 8'hFE, 8'hFF};

`ifdef SUB_SIGNED_OVF_EN
    expv = 1'b1;
`else
    expv = 1'b0;
`endif

    b16.start = 1'b0; b16.A = '0; b16.B = '0;
    b8.start  = 1'b0; b8.A  = '0; b8.B  = '0;
    b1.start  = 1'b0; b1.A  = '0; b1.B  = '0;

    #2;
    chk("rst_busy", b16.busy, 0);
    chk("rst_done", b16.done, 0);
    chk("rst_d",    b16.D,    0);
    chk("rst_bout", b16.Bout, 0);
    chk("rst_v",    b16.V,    0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run16(16'h1234, 16'h0034, lat, bsy);
    chk("t1_busy", bsy, 1);
    chk("t1_lat",  lat, 3);
    chk("t1_d",    b16.D, 16'h1200);
    chk("t1_bout", b16.Bout, 0);
    chk("t1_v",    b16.V, 0);

    run16(16'h0100, 16'h0001, lat, bsy);
    chk("t2_lat",  lat, 3);
    chk("t2_d",    b16.D, 16'h00FF);
    chk("t2_bout", b16.Bout, 0);

    run16(16'h0000, 16'h0001, lat, bsy);
    chk("t3_d",    b16.D, 16'hFFFF);
    chk("t3_bout", b16.Bout, 1);
    chk("t3_v",    b16.V, 0);

    run16(16'h8000, 16'h0001, lat, bsy);
    chk("t4_d",    b16.D, 16'h7FFF);
    chk("t4_bout", b16.Bout, 0);
    chk("t4_v",    b16.V, {31'd0, expv});

    @(negedge clk);
    // start while busy must be ignored
    b16.A = 16'h0005; b16.B = 16'h0003; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    chk("t5_busy1", b16.busy, 1);
    b16.A = 16'hFFFF; b16.B = 16'h0000; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    chk("t5_busy2", b16.busy, 1);
    @(negedge clk);
    chk("t5_done", b16.done, 1);
    chk("t5_d",    b16.D, 16'h0002);
    ndone = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (b16.done) ndone++;
    end
    chk("t5_extra_done", ndone, 0);
    chk("t5_d_held",     b16.D, 16'h0002);

    run16(16'h0010, 16'h0001, lat, bsy);
    chk("t6a_d", b16.D, 16'h000F);
    // issued in the DONE cycle: back-to-back
    run16(16'h0003, 16'h0005, lat, bsy);
    chk("t6b_busy", bsy, 1);
    chk("t6b_lat",  lat, 3);
    chk("t6b_d",    b16.D, 16'hFFFE);
    chk("t6b_bout", b16.Bout, 1);

    run16(16'h8000, 16'h0001, lat, bsy);
    chk("t7pre_v", b16.V, {31'd0, expv});
    b16.A = 16'h1234; b16.B = 16'h0001; b16.start = 1'b1;
    @(negedge clk);
    b16.start = 1'b0;
    @(negedge clk);
    chk("t7_midrun", b16.busy, 1);
    reset = 1'b1;
    #1;
    chk("t7_busy", b16.busy, 0);
    chk("t7_done", b16.done, 0);
    chk("t7_d",    b16.D, 0);
    chk("t7_bout", b16.Bout, 0);
    chk("t7_v",    b16.V, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t7_idle", b16.busy, 0);
    run16(16'h00FF, 16'h00FF, lat, bsy);
    chk("t7b_lat",  lat, 3);
    chk("t7b_d",    b16.D, 16'h0000);
    chk("t7b_bout", b16.Bout, 0);

    // K=1: one RUN cycle, done one cycle later
    @(negedge clk);
    b1.A = 8'h10; b1.B = 8'h20; b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    lat = 1;
    while (!b1.done && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("k1_lat",  lat, 2);
    chk("k1_d",    b1.D, 8'hF0);
    chk("k1_bout", b1.Bout, 1);

    // W=8/N=4: every A against boundary B values and B=A
    for (int a = 0; a < 256; a++) begin
      for (int j = 0; j < 9; j++) begin
        bv = (j == 8) ? 8'(a) : blist[j];
        @(negedge clk);
        b8.A = 8'(a); b8.B = bv; b8.start = 1'b1;
        @(negedge clk);
        b8.start = 1'b0;
        lat = 1;
        while (!b8.done && lat < 12) begin
          @(negedge clk);
          lat++;
        end
        s = a + 256 - int'(bv);
        chk("swp_lat",  lat, 3);
        chk("swp_d",    {~b8.Bout, b8.D}, s[8:0]);
        chk("swp_bout", b8.Bout, (a < int'(bv)) ? 1 : 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
